// File: rtl/atm_session_ctrl_if.sv
// atm_if: ATM front-panel bus between the panel (master) and the session controller (slave).
//   card_in, key_valid, key, enter, cancel, sel, amount : panel -> controller
//   state, balance, dispense, eject, error              : controller -> panel
interface atm_if #(parameter int BAL_W = 8);
  logic             card_in;
  logic             key_valid;
  logic [3:0]       key;
  logic             enter;
  logic             cancel;
  logic [1:0]       sel;
  logic [BAL_W-1:0] amount;
  logic [2:0]       state;
  logic [BAL_W-1:0] balance;
  logic             dispense;
  logic             eject;
  logic             error;
  modport master (
    output card_in, key_valid, key, enter, cancel, sel, amount,
    input  state, balance, dispense, eject, error
  );
  modport slave (
    input  card_in, key_valid, key, enter, cancel, sel, amount,
    output state, balance, dispense, eject, error
  );
endinterface

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: one-card ATM session FSM (PIN, menu, withdraw/deposit/balance, lockout, timeout).
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : atm_if slave port (panel strobes/levels in; state code, balance, dispense, eject, error out)
module atm_session_ctrl #(
  parameter logic [15:0] PIN_CODE  = 16'h1234,
  parameter int          MAX_TRIES = 3,
  parameter int          TIMEOUT   = 255,
  parameter int          BAL_W     = 8,
  parameter int          INIT_BAL  = 100
) (
  input logic  clock,
  input logic  resetn,
  atm_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PIN, MENU, WITHDRAW, DEPOSIT, BALANCE, LOCKED, EJECT} state_t;
  localparam logic [2:0] MAXT = 3'(MAX_TRIES);
  state_t           st, st_n;
  logic [BAL_W-1:0] bal, bal_n;
  logic [2:0]       tries, tries_n, cnt, cnt_n;
  logic [15:0]      digits, digits_n;
  logic [7:0]       timer;
  logic             dis, dis_n, err, err_n;
  logic             active, strobe, tmo;
  logic [BAL_W:0]   sum;
  assign active = st inside {PIN, MENU, WITHDRAW, DEPOSIT, BALANCE};
  assign strobe = bus.key_valid | bus.enter | bus.cancel;
  // timer holds the idle cycles already elapsed, so the TIMEOUT-th idle edge ejects
  assign tmo    = active && ({1'b0, timer} + 9'd1 == 9'(TIMEOUT));
  assign sum    = {1'b0, bal} + {1'b0, bus.amount};
  always_comb begin
    st_n     = st;
    bal_n    = bal;
    tries_n  = tries;
    digits_n = digits;
    cnt_n    = cnt;
    dis_n    = 1'b0;
    err_n    = st == LOCKED;
    if (st == LOCKED) begin
      st_n = LOCKED;
    end else if (!bus.card_in) begin
      st_n = IDLE;
    end else if (bus.cancel && active) begin
      st_n = EJECT;
    end else if (tmo) begin
      st_n = EJECT;
    end else begin
      case (st)
        IDLE: begin
          st_n     = PIN;
          digits_n = '0;
          cnt_n    = '0;
        end
        PIN: begin
          if (bus.enter) begin
            if (cnt == 3'd4 && digits == PIN_CODE) begin
              st_n    = MENU;
              tries_n = '0;
            end else if (tries + 3'd1 == MAXT) begin
              st_n  = LOCKED;
              err_n = 1'b1;
            end else begin
              tries_n  = tries + 3'd1;
              digits_n = '0;
              cnt_n    = '0;
              err_n    = 1'b1;
            end
          end else if (bus.key_valid && bus.key <= 4'd9 && cnt < 3'd4) begin
            digits_n = {digits[11:0], bus.key};
            cnt_n    = cnt + 3'd1;
          end
        end
        MENU: begin
          if (bus.enter) begin
            st_n  = bus.sel == 2'b01 ? WITHDRAW : bus.sel == 2'b10 ? DEPOSIT :
                    bus.sel == 2'b11 ? BALANCE : MENU;
            err_n = bus.sel == 2'b00;
          end
        end
        WITHDRAW: begin
          if (bus.enter) begin
            if (bus.amount != '0 && bus.amount <= bal) begin
              bal_n = bal - bus.amount;
              dis_n = 1'b1;
              st_n  = EJECT;
            end else begin
              err_n = 1'b1;
              st_n  = MENU;
            end
          end
        end
        DEPOSIT: begin
          if (bus.enter) begin
            // a carry out would wrap the balance, so the deposit is refused instead
            bal_n = sum[BAL_W] ? bal : sum[BAL_W-1:0];
            err_n = sum[BAL_W];
            st_n  = MENU;
          end
        end
        BALANCE: st_n = bus.enter ? MENU : BALANCE;
        default: st_n = st;
      endcase
    end
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      st     <= IDLE;
      bal    <= BAL_W'(INIT_BAL);
      tries  <= '0;
      digits <= '0;
      cnt    <= '0;
      timer  <= '0;
      dis    <= 1'b0;
      err    <= 1'b0;
    end else begin
      st     <= st_n;
      bal    <= bal_n;
      tries  <= tries_n;
      digits <= digits_n;
      cnt    <= cnt_n;
      timer  <= (st_n != st || strobe || !active) ? 8'd0 : timer + 8'd1;
      dis    <= dis_n;
      err    <= err_n;
    end
  end
  assign bus.state    = st;
  assign bus.balance  = bal;
  assign bus.dispense = dis;
  assign bus.error    = err;
  assign bus.eject    = st == EJECT;
endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: scoreboard bench for atm_session_ctrl (per-cycle expected outputs queued with stimulus).
module tb_atm_session_ctrl;
  localparam int T = 255;
  localparam logic [2:0] S_IDLE = 3'd0, S_PIN = 3'd1, S_MENU = 3'd2, S_WD = 3'd3,
                         S_DEP = 3'd4, S_BAL = 3'd5, S_LOCK = 3'd6, S_EJ = 3'd7;
  typedef struct packed {
    logic [2:0] st;
    logic [7:0] bal;
    logic       dis;
    logic       err;
    logic       ej;
  } obs_t;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  obs_t expq[$];
  obs_t gotq[$];
  int   n_run = 0;
  int   n_fail = 0;
  atm_if #(.BAL_W(8)) bus();
  atm_session_ctrl #(
    .PIN_CODE(16'h1234), .MAX_TRIES(3), .TIMEOUT(T), .BAL_W(8), .INIT_BAL(100)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .bus(bus)
  );
  always #5 clock = ~clock;
  task automatic step(input logic c, kv, input logic [3:0] k, input logic e, ca,
                      input logic [1:0] s, input logic [7:0] a,
                      input logic [2:0] xst, input logic [7:0] xbal, input logic xdis, xerr);
    bus.card_in = c;
    bus.key_valid = kv;
    bus.key = k;
    bus.enter = e;
    bus.cancel = ca;
    bus.sel = s;
    bus.amount = a;
    expq.push_back({xst, xbal, xdis, xerr, xst == S_EJ});
    @(posedge clock);
    #1;
    bus.key_valid = 1'b0;
    bus.enter = 1'b0;
    bus.cancel = 1'b0;
    gotq.push_back({bus.state, bus.balance, bus.dispense, bus.error, bus.eject});
  endtask
  task automatic idle(input logic c, input logic [2:0] xst, input logic [7:0] xbal);
    step(c, 0, 0, 0, 0, 0, 0, xst, xbal, 0, 0);
  endtask
  task automatic pin4(input logic [15:0] d, input logic [7:0] xbal);
    for (int i = 3; i >= 0; i--) step(1, 1, d[i*4 +: 4], 0, 0, 0, 0, S_PIN, xbal, 0, 0);
  endtask
  task automatic login(input logic [7:0] xbal);
    idle(1, S_PIN, xbal);
    pin4(16'h1234, xbal);
    step(1, 0, 0, 1, 0, 0, 0, S_MENU, xbal, 0, 0);
  endtask
  task automatic do_reset();
    bus.card_in = 1'b0;
    bus.key_valid = 1'b0;
    bus.enter = 1'b0;
    bus.cancel = 1'b0;
    bus.key = '0;
    bus.sel = '0;
    bus.amount = '0;
    resetn = 1'b0;
    #7;
    resetn = 1'b1;
  endtask
  task automatic test_reset();
    obs_t g;
    do_reset();
    g = {bus.state, bus.balance, bus.dispense, bus.error, bus.eject};
    n_run++;
    if (g !== {S_IDLE, 8'd100, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: got st=%0d bal=%0d dis=%b err=%b ej=%b, want st=0 bal=100 dis=0 err=0 ej=0",
               g.st, g.bal, g.dis, g.err, g.ej);
    end
  endtask
  task automatic test_login_withdraw();
    obs_t e, g;
    int n = 0;
    login(100);
    step(1, 0, 0, 1, 0, 2'b01, 0, S_WD, 100, 0, 0);
    step(1, 0, 0, 1, 0, 0, 40, S_EJ, 60, 1, 0);
    idle(1, S_EJ, 60);
    step(1, 0, 0, 0, 1, 0, 0, S_EJ, 60, 0, 0);
    idle(0, S_IDLE, 60);
    while (expq.size() > 0) begin
      e = expq.pop_front();
      g = gotq.pop_front();
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL login_withdraw[%0d]: got st=%0d bal=%0d dis=%b err=%b ej=%b, want st=%0d bal=%0d dis=%b err=%b ej=%b",
                 n, g.st, g.bal, g.dis, g.err, g.ej, e.st, e.bal, e.dis, e.err, e.ej);
      end
      n++;
    end
  endtask
  task automatic test_transactions();
    obs_t e, g;
    int n = 0;
    login(60);
    step(1, 0, 0, 1, 0, 2'b01, 0, S_WD, 60, 0, 0);
    do_reset();
    g = {bus.state, bus.balance, bus.dispense, bus.error, bus.eject};
    n_run++;
    if (g !== {S_IDLE, 8'd100, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_txn: got st=%0d bal=%0d, want st=0 bal=100", g.st, g.bal);
    end
    login(100);
    step(1, 0, 0, 1, 0, 2'b01, 0, S_WD, 100, 0, 0);
    step(1, 0, 0, 1, 0, 0, 101, S_MENU, 100, 0, 1);
    step(1, 0, 0, 1, 0, 2'b10, 0, S_DEP, 100, 0, 0);
    step(1, 0, 0, 1, 0, 0, 200, S_MENU, 100, 0, 1);
    step(1, 0, 0, 1, 0, 2'b10, 0, S_DEP, 100, 0, 0);
    step(1, 0, 0, 1, 0, 0, 155, S_MENU, 255, 0, 0);
    step(1, 0, 0, 1, 0, 2'b10, 0, S_DEP, 255, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, S_MENU, 255, 0, 0);
    step(1, 0, 0, 1, 0, 2'b00, 0, S_MENU, 255, 0, 1);
    step(1, 0, 0, 1, 0, 2'b11, 0, S_BAL, 255, 0, 0);
    idle(1, S_BAL, 255);
    step(1, 0, 0, 1, 0, 0, 0, S_MENU, 255, 0, 0);
    step(1, 0, 0, 1, 0, 2'b01, 0, S_WD, 255, 0, 0);
    step(1, 0, 0, 1, 0, 0, 255, S_EJ, 0, 1, 0);
    idle(0, S_IDLE, 0);
    login(0);
    step(1, 0, 0, 1, 0, 2'b10, 0, S_DEP, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 5, S_IDLE, 0, 0, 0);
    login(0);
    step(1, 0, 0, 1, 0, 2'b01, 0, S_WD, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, S_MENU, 0, 0, 1);
    step(1, 0, 0, 0, 1, 0, 0, S_EJ, 0, 0, 0);
    idle(0, S_IDLE, 0);
    while (expq.size() > 0) begin
      e = expq.pop_front();
      g = gotq.pop_front();
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL transactions[%0d]: got st=%0d bal=%0d dis=%b err=%b ej=%b, want st=%0d bal=%0d dis=%b err=%b ej=%b",
                 n, g.st, g.bal, g.dis, g.err, g.ej, e.st, e.bal, e.dis, e.err, e.ej);
      end
      n++;
    end
  endtask
  task automatic test_lockout();
    obs_t e, g;
    int n = 0;
    do_reset();
    idle(1, S_PIN, 100);
    pin4(16'h9999, 100);
    step(1, 0, 0, 1, 0, 0, 0, S_PIN, 100, 0, 1);
    idle(0, S_IDLE, 100);
    idle(1, S_PIN, 100);
    pin4(16'h9999, 100);
    step(1, 0, 0, 1, 0, 0, 0, S_PIN, 100, 0, 1);
    pin4(16'h9999, 100);
    step(1, 0, 0, 1, 0, 0, 0, S_LOCK, 100, 0, 1);
    step(1, 1, 1, 0, 0, 0, 0, S_LOCK, 100, 0, 1);
    step(1, 0, 0, 0, 1, 0, 0, S_LOCK, 100, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, S_LOCK, 100, 0, 1);
    step(1, 0, 0, 1, 0, 2'b01, 0, S_LOCK, 100, 0, 1);
    while (expq.size() > 0) begin
      e = expq.pop_front();
      g = gotq.pop_front();
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL lockout[%0d]: got st=%0d bal=%0d dis=%b err=%b ej=%b, want st=%0d bal=%0d dis=%b err=%b ej=%b",
                 n, g.st, g.bal, g.dis, g.err, g.ej, e.st, e.bal, e.dis, e.err, e.ej);
      end
      n++;
    end
    do_reset();
    g = {bus.state, bus.balance, bus.dispense, bus.error, bus.eject};
    n_run++;
    if (g !== {S_IDLE, 8'd100, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL unlock_reset: got st=%0d bal=%0d err=%b, want st=0 bal=100 err=0", g.st, g.bal, g.err);
    end
  endtask
  task automatic test_pin_edges();
    obs_t e, g;
    int n = 0;
    idle(1, S_PIN, 100);
    step(1, 1, 4'hA, 0, 0, 0, 0, S_PIN, 100, 0, 0);
    pin4(16'h1234, 100);
    step(1, 1, 4'd5, 0, 0, 0, 0, S_PIN, 100, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, S_MENU, 100, 0, 0);
    idle(0, S_IDLE, 100);
    idle(1, S_PIN, 100);
    for (int i = 1; i <= 3; i++) step(1, 1, 4'(i), 0, 0, 0, 0, S_PIN, 100, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, S_PIN, 100, 0, 1);
    pin4(16'h1234, 100);
    step(1, 0, 0, 1, 0, 0, 0, S_MENU, 100, 0, 0);
    idle(0, S_IDLE, 100);
    idle(1, S_PIN, 100);
    pin4(16'h1234, 100);
    step(1, 0, 0, 1, 1, 0, 0, S_EJ, 100, 0, 0);
    idle(0, S_IDLE, 100);
    while (expq.size() > 0) begin
      e = expq.pop_front();
      g = gotq.pop_front();
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL pin_edges[%0d]: got st=%0d bal=%0d dis=%b err=%b ej=%b, want st=%0d bal=%0d dis=%b err=%b ej=%b",
                 n, g.st, g.bal, g.dis, g.err, g.ej, e.st, e.bal, e.dis, e.err, e.ej);
      end
      n++;
    end
  endtask
  task automatic test_timeout();
    obs_t e, g;
    int n = 0;
    login(100);
    repeat (T - 2) idle(1, S_MENU, 100);
    step(1, 1, 4'd7, 0, 0, 0, 0, S_MENU, 100, 0, 0);
    repeat (T - 1) idle(1, S_MENU, 100);
    idle(1, S_EJ, 100);
    idle(0, S_IDLE, 100);
    login(100);
    repeat (T - 1) idle(1, S_MENU, 100);
    idle(1, S_EJ, 100);
    idle(0, S_IDLE, 100);
    while (expq.size() > 0) begin
      e = expq.pop_front();
      g = gotq.pop_front();
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL timeout[%0d]: got st=%0d bal=%0d dis=%b err=%b ej=%b, want st=%0d bal=%0d dis=%b err=%b ej=%b",
                 n, g.st, g.bal, g.dis, g.err, g.ej, e.st, e.bal, e.dis, e.err, e.ej);
      end
      n++;
    end
  endtask
  initial begin
    test_reset();
    test_login_withdraw();
    test_transactions();
    test_lockout();
    test_pin_edges();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
